detector_sched: RTL and testbench

- Sequencing/admission controller for the pipelined K-best detector chain: STAGES cascaded detector stages, each a fixed STAGE_LAT-cycle free-running pipeline with no stall input.
- Accepts received-vector jobs over a valid/ready handshake and emits per-stage load strobes so each stage's R-row/Y input registers capture at the right cycle.
- Flags results leaving the last stage into an external result FIFO, throttled by credit-based flow control.
- Also brackets reconfiguration by draining the chain before pulsing a config load.

---
 rtl/detector_sched_pkg.sv | 19 +
 rtl/sched_token_pipe.sv | 54 +++++
 rtl/detector_sched.sv | 126 ++++++++++++
 tb/tb_detector_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/detector_sched_pkg.sv
// Shared state encodings and default sizing for the K-best detector sequencer.
package detector_sched_pkg;

   localparam int unsigned WL        = 16;
   localparam int unsigned ERR_WL    = 8;

   localparam int unsigned STAGES_DEF    = 4;
   localparam int unsigned STAGE_LAT_DEF = 4;
   localparam int unsigned CREDITS_DEF   = 4;
   localparam int unsigned TAG_W_DEF     = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_CFG   = 2'd3
   } sched_state_e;

endpackage

// File: rtl/sched_token_pipe.sv
// {valid, tag} token shift register mirroring the detector chain; one tap per stage entry.
module sched_token_pipe
   import detector_sched_pkg::*;
#(
   parameter int unsigned STAGES    = STAGES_DEF,
   parameter int unsigned STAGE_LAT = STAGE_LAT_DEF,
   parameter int unsigned TAG_W     = TAG_W_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      acc_i,
   input  logic [TAG_W-1:0]          tag_i,
   output logic [STAGES-1:0]         tap_vld_o,
   output logic [STAGES*TAG_W-1:0]   tap_tag_o,
   output logic                      out_vld_o,
   output logic [TAG_W-1:0]          out_tag_o,
   output logic                      busy_o
);

   localparam int unsigned L = STAGES * STAGE_LAT;

   // Entry 0 is the accept itself; register j holds the token j cycles after accept.
   logic [L:1]       vld_q;
   logic [TAG_W-1:0] tag_q [L:1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         for (int unsigned j = 1; j <= L; j++) tag_q[j] <= '0;
      end else begin
         vld_q    <= flush_i ? '0 : {vld_q[L-1:1], acc_i};
         tag_q[1] <= tag_i;
         for (int unsigned j = 2; j <= L; j++) tag_q[j] <= tag_q[j-1];
      end
   end

   always_comb begin
      tap_vld_o            = '0;
      tap_tag_o            = '0;
      tap_vld_o[0]         = acc_i;
      tap_tag_o[TAG_W-1:0] = tag_i;
      for (int unsigned k = 1; k < STAGES; k++) begin
         tap_vld_o[k]                 = vld_q[k*STAGE_LAT];
         tap_tag_o[k*TAG_W +: TAG_W]  = tag_q[k*STAGE_LAT];
      end
   end

   assign out_vld_o = vld_q[L];
   assign out_tag_o = tag_q[L];
   // The token leaving the last stage is no longer counted as in flight.
   assign busy_o    = acc_i | (|vld_q[L-1:1]);

endmodule

// File: rtl/detector_sched.sv
// Admission/sequencing controller for the pipelined K-best detector chain with credit flow control.
module detector_sched
   import detector_sched_pkg::*;
#(
   parameter int unsigned STAGES    = STAGES_DEF,
   parameter int unsigned STAGE_LAT = STAGE_LAT_DEF,
   parameter int unsigned CREDITS   = CREDITS_DEF,
   parameter int unsigned TAG_W     = TAG_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      flush,
   input  logic                      cfg_req,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [STAGES-1:0]         stage_ld,
   output logic [STAGES*TAG_W-1:0]   stage_tag,
   output logic                      out_push,
   output logic [TAG_W-1:0]          out_tag,
   input  logic                      out_pop,
   output logic                      cfg_load,
   output logic                      busy,
   output logic                      err_pop
);

   localparam int unsigned      CNT_W    = $clog2(CREDITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);

   sched_state_e     state_q;
   logic             cfg_load_q;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             accept;
   logic             pipe_out_vld;
   logic             busy_w;

   assign in_ready = (state_q == ST_RUN) && (cnt_q != '0) && !flush;
   assign accept   = in_valid && in_ready;

   sched_token_pipe #(
      .STAGES    (STAGES),
      .STAGE_LAT (STAGE_LAT),
      .TAG_W     (TAG_W)
   ) u_pipe (
      .clk_i     (clk),
      .rst_ni    (rst),
      .flush_i   (flush),
      .acc_i     (accept),
      .tag_i     (tag_q),
      .tap_vld_o (stage_ld),
      .tap_tag_o (stage_tag),
      .out_vld_o (pipe_out_vld),
      .out_tag_o (out_tag),
      .busy_o    (busy_w)
   );

   // Tokens reaching the end in a flush cycle are being aborted, so they never hit the FIFO.
   assign out_push = pipe_out_vld && !flush;
   assign busy     = busy_w;
   assign cfg_load = cfg_load_q;
   assign err_pop  = err_q;

   always_comb begin
      cnt_d = cnt_q;
      tag_d = tag_q;
      err_d = err_q | (out_pop && (cnt_q == CNT_FULL));
      if (flush) begin
         cnt_d = CNT_FULL;
         tag_d = '0;
      end else begin
         if (accept && !out_pop)
            cnt_d = cnt_q - CNT_W'(1);
         else if (!accept && out_pop && (cnt_q != CNT_FULL))
            cnt_d = cnt_q + CNT_W'(1);
         if (accept)
            tag_d = tag_q + TAG_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= CNT_FULL;
         tag_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tag_q <= tag_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cfg_load_q <= 1'b0;
      end else if (flush) begin
         state_q    <= ST_IDLE;
         cfg_load_q <= 1'b0;
      end else begin
         cfg_load_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (cfg_req) begin
                  state_q    <= ST_CFG;
                  cfg_load_q <= 1'b1;
               end else if (en) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (cfg_req || !en) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!busy_w) state_q <= ST_IDLE;
            end
            ST_CFG: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_detector_sched.sv
// Directed scoreboard bench for detector_sched: driver queues expected strobes/pushes, monitor checks them.
module tb_detector_sched;

   localparam int unsigned STAGES    = 4;
   localparam int unsigned STAGE_LAT = 4;
   localparam int unsigned CREDITS   = 4;
   localparam int unsigned TAG_W     = 4;
   localparam int          L         = STAGES * STAGE_LAT;

   logic                    clk = 1'b0;
   logic                    rst, en, flush, cfg_req, in_valid, out_pop;
   logic                    in_ready, out_push, cfg_load, busy, err_pop;
   logic [STAGES-1:0]       stage_ld;
   logic [STAGES*TAG_W-1:0] stage_tag;
   logic [TAG_W-1:0]        out_tag;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mtag  = 0;

   typedef struct packed {
      int         cyc;
      int         k;
      logic [3:0] tag;
   } ev_t;

   ev_t sq[$];
   ev_t pq[$];

   detector_sched #(
      .STAGES    (STAGES),
      .STAGE_LAT (STAGE_LAT),
      .CREDITS   (CREDITS),
      .TAG_W     (TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .cfg_req   (cfg_req),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .stage_ld  (stage_ld),
      .stage_tag (stage_tag),
      .out_push  (out_push),
      .out_tag   (out_tag),
      .out_pop   (out_pop),
      .cfg_load  (cfg_load),
      .busy      (busy),
      .err_pop   (err_pop)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compares stage strobes and FIFO pushes against the scoreboard queues.
   always @(negedge clk) begin
      logic [STAGES-1:0]       ev;
      logic [STAGES*TAG_W-1:0] et;
      ev_t                     e;
      if (rst === 1'b1) begin
         ev = '0;
         et = '0;
         for (int i = sq.size() - 1; i >= 0; i--) begin
            if (sq[i].cyc == cyc) begin
               ev[sq[i].k]            = 1'b1;
               et[sq[i].k*4 +: 4]     = sq[i].tag;
               sq.delete(i);
            end
         end
         if (ev != '0 || stage_ld != '0) begin
            chk("stage_ld", 32'(stage_ld), 32'(ev));
            for (int k = 0; k < STAGES; k++)
               if (ev[k]) chk("stage_tag", 32'(stage_tag[k*4 +: 4]), 32'(et[k*4 +: 4]));
         end
         if (out_push) begin
            if (pq.size() == 0) begin
               chk("push_unexpected", 32'(out_push), 32'd0);
            end else begin
               e = pq.pop_front();
               chk("push_cycle", 32'(cyc), 32'(e.cyc));
               chk("out_tag", 32'(out_tag), 32'(e.tag));
            end
         end else if (pq.size() != 0 && pq[0].cyc < cyc) begin
            e = pq.pop_front();
            chk("push_missing", 32'(out_push), 32'd1);
         end
      end
   end

   // One driver cycle: inputs set just after posedge, checks at negedge; -1 skips a check.
   task automatic step(input logic v, input logic p, input int er, input int eb, input int ec);
      in_valid = v;
      out_pop  = p;
      if (v && er == 1) begin
         for (int k = 0; k < STAGES; k++)
            sq.push_back('{cyc: cyc + k*STAGE_LAT, k: k, tag: 4'(mtag)});
         pq.push_back('{cyc: cyc + L, k: 0, tag: 4'(mtag)});
         mtag = (mtag + 1) % 16;
      end
      @(negedge clk);
      if (er >= 0) chk("in_ready", 32'(in_ready), 32'(er));
      if (eb >= 0) chk("busy", 32'(busy), 32'(eb));
      if (ec >= 0) chk("cfg_load", 32'(cfg_load), 32'(ec));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sq.size() != 0 || pq.size() != 0) && n < 60) begin
         step(1'b0, 1'b0, -1, -1, 0);
         n++;
      end
      if (n >= 60) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sq.size() + pq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; en = 1'b0; flush = 1'b0; cfg_req = 1'b0;
      in_valid = 1'b0; out_pop = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_stage_ld", 32'(stage_ld), 32'd0);
      chk("rst_stage_tag", 32'(stage_tag), 32'd0);
      chk("rst_out_push", 32'(out_push), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_cfg_load", 32'(cfg_load), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_pop", 32'(err_pop), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      en  = 1'b1;

      // Single job through the chain.
      step(1'b0, 1'b0, 0, 0, 0);
      step(1'b0, 1'b0, 1, 0, 0);
      step(1'b1, 1'b0, 1, 1, 0);
      repeat (15) step(1'b0, 1'b0, 1, 1, 0);
      step(1'b0, 1'b0, 1, 0, 0);
      step(1'b0, 1'b1, 1, 0, 0);

      // Credit stall, pop releases exactly one more accept.
      repeat (4) step(1'b1, 1'b0, 1, -1, 0);
      repeat (2) step(1'b1, 1'b0, 0, -1, 0);
      step(1'b1, 1'b1, 0, -1, 0);
      step(1'b1, 1'b0, 1, -1, 0);
      step(1'b0, 1'b0, 0, -1, 0);

      // Accept and pop together at one credit.
      step(1'b0, 1'b1, 0, -1, 0);
      step(1'b1, 1'b1, 1, -1, 0);
      step(1'b0, 1'b0, 1, -1, 0);
      repeat (3) step(1'b0, 1'b1, 1, -1, 0);
      drain();

      // Reconfiguration with two jobs in flight.
      step(1'b1, 1'b0, 1, -1, 0);
      step(1'b1, 1'b0, 1, -1, 0);
      cfg_req = 1'b1;
      step(1'b0, 1'b0, 1, 1, 0);
      for (int off = 3; off <= 21; off++) begin
         if (off == 20) cfg_req = 1'b0;
         step(1'b0, 1'b0, (off == 21) ? 1 : 0, (off <= 16) ? 1 : 0, (off == 19) ? 1 : 0);
      end
      repeat (2) step(1'b0, 1'b1, 1, 0, 0);

      // Flush with three jobs in flight.
      repeat (3) step(1'b1, 1'b0, 1, 1, 0);
      flush = 1'b1;
      sq.delete();
      pq.delete();
      step(1'b0, 1'b0, 0, 1, 0);
      flush = 1'b0;
      mtag  = 0;
      step(1'b0, 1'b0, 0, 0, 0);
      step(1'b1, 1'b0, 1, 1, 0);
      repeat (20) step(1'b0, 1'b0, 1, -1, 0);
      step(1'b0, 1'b1, 1, 0, 0);

      // Tag wrap over 17 jobs, then a spurious pop.
      flush = 1'b1;
      step(1'b0, 1'b0, 0, 0, 0);
      flush = 1'b0;
      mtag  = 0;
      step(1'b0, 1'b0, 0, 0, 0);
      for (int j = 0; j < 17; j++) begin
         step(1'b1, 1'b0, 1, 1, 0);
         repeat (16) step(1'b0, 1'b0, 1, -1, 0);
         step(1'b0, 1'b1, 1, 0, 0);
      end
      chk("err_pop_before", 32'(err_pop), 32'd0);
      step(1'b0, 1'b1, 1, 0, 0);
      repeat (3) begin
         step(1'b0, 1'b0, 1, 0, 0);
         chk("err_pop_sticky", 32'(err_pop), 32'd1);
      end
      chk("sb_stage_empty", 32'(sq.size()), 32'd0);
      chk("sb_push_empty", 32'(pq.size()), 32'd0);

      rst = 1'b0;
      @(negedge clk);
      chk("err_pop_rst", 32'(err_pop), 32'd0);
      chk("rst_in_ready2", 32'(in_ready), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
